cordic_cos_fixed: RTL and testbench
===================================

Name: cordic_cos_fixed

Overview:
Iterative rotation-mode CORDIC that computes cos(angle) for a signed fixed-point angle in radians. It sits directly upstream of the fixed-point-to-IEEE-754 converter. Its result is emitted in the converter's input format: sign bit, one integer bit and 19 fractional bits. It takes one micro-rotation per clock, with a valid/ready handshake on both sides.

Parameters:
FRAC_W, 19, fractional bits of angle and result (downstream fixed at 19)
ITER, 16, number of micro-rotations (range 8..FRAC_W)
GUARD, 2, extra LSBs carried internally in x/y/z, truncated at output

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
valid_i  input  1  angle_i valid
ready_o  output  1  block can accept an angle
angle_i  input  FRAC_W+2  two's-complement angle, Q2.19 (range [-2,2) rad)
valid_o  output  1  result valid, held until accepted
ready_i  input  1  downstream accepts the result
sign_o  output  1  sign of cos result (1 = negative)
integer_o  output  1  integer bit of |cos|
fractional_o  output  FRAC_W  fractional bits of |cos|

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n. rst_n=0 at a clk edge forces state IDLE, valid_o=0, sign_o=0, integer_o=0, fractional_o=0 and internal x/y/z/count=0. This applies in any state, including mid-rotation; the in-flight result is discarded.
- FSM states: IDLE, ROTATE, DONE. ready_o=1 only in IDLE; valid_o=1 only in DONE.
- IDLE: on valid_i & ready_o, capture the angle, load x=K, y=0, z=angle, count=0, and go to ROTATE.
- K = 0.6072529350 * 2^FRAC_W. For FRAC_W=19 this is 318375 = 0x4DBA7, shifted left by GUARD.
- Angle clamp at capture: angle > +1.0 (0x080000) loads +1.0; angle < -1.0 (0x180000) loads -1.0. Exactly ±1.0 passes unchanged.
- ROTATE: each cycle, with d = (z >= 0):
  - x' = x - d*(y>>>count)
  - y' = y + d*(x>>>count)
  - z' = z - d*atan(2^-count)
  - where d*v means +v if d=1, -v otherwise. Shifts are arithmetic. Internal width is FRAC_W+GUARD+3 bits signed.
  - count increments each cycle. After the rotation with count=ITER-1, go to DONE and register the outputs on the same edge.
- Output formatting, applied to the final x (after dropping GUARD LSBs by truncation):
  - sign_o = x[MSB].
  - mag = |x|. If mag >= 2^FRAC_W, saturate to integer_o=1, fractional_o=0. Otherwise integer_o=0 and fractional_o=mag[FRAC_W-1:0].
  - Exactly 1.0 is therefore always integer_o=1, fractional_o=0.
- DONE: outputs stable while valid_o=1 and ready_i=0. On ready_i=1, go to IDLE; valid_o drops on the next edge.
- No new capture occurs in DONE. A valid_i pulse while ready_o=0 is ignored, not queued.
- Latency: accept edge t gives valid_o=1 from edge t+ITER. Throughput is 1 result per ITER+2 cycles with ready_i tied high.
- Accuracy: |result - cos(angle_clamped)| <= 8 LSB (2^-16) for ITER=16 over [-1,1] rad.
- Output is never negative in the clamped range. sign_o is still driven from x for generality.

Decomposition:
- Package cordic_pkg holds:
  - FRAC_W default
  - K_SCALED constant
  - the atan(2^-i)*2^(FRAC_W+GUARD) rounded table as a constant array of length FRAC_W
  - the state enum {IDLE, ROTATE, DONE}
  - ANGLE_POS_LIMIT / ANGLE_NEG_LIMIT constants
- One sub-module, cordic_atan_rom: combinational index-to-atan lookup reading the package table, instanced once.
- Micro-rotation datapath and FSM stay in the top.

Test Plan:
- Reset then angle_i=0x000000 with valid_i pulse, ready_i=1 -> valid_o at +16 cycles; sign_o=0, integer_o=1, fractional_o=0 (saturated 1.0).
- angle_i=0x080000 (+1.0) -> sign_o=0, integer_o=0, fractional_o = 0x4528A ±8.
- angle_i=0x1C0000 (-0.5) -> sign_o=0, integer_o=0, fractional_o = 0x7054A ±8. Also check ready_o=0 for cycles 1..17 after accept.
- angle_i=0x0C0000 (+1.5, out of range) -> clamped; result identical to the +1.0 case (0x4528A ±8).
- Backpressure: ready_i=0 for 10 cycles after valid_o rises -> valid_o and outputs unchanged; valid_i pulses during DONE ignored. ready_i=1 -> IDLE next edge, ready_o=1.
- Reset mid-operation: rst_n=0 at rotation 7 -> next edge valid_o=0, ready_o=1, outputs 0. Next angle 0x080000 yields the correct result with full latency.

Source files
------------

// File: rtl/cordic_cos_fixed_pkg.sv
// Shared constants, arctangent table and FSM state type for the cosine CORDIC.
package cordic_pkg;

    localparam int unsigned CORDIC_FRAC_W = 19;
    localparam int unsigned CORDIC_GUARD  = 2;
    localparam int unsigned ANGLE_W       = CORDIC_FRAC_W + 2;
    localparam int unsigned ATAN_W        = CORDIC_FRAC_W + CORDIC_GUARD;

    // CORDIC gain compensation 0.6072529350 in Q0.FRAC_W, guard bits added at load.
    localparam logic [CORDIC_FRAC_W-1:0] K_SCALED = CORDIC_FRAC_W'(318375);

    localparam logic signed [ANGLE_W-1:0] ANGLE_POS_LIMIT = ANGLE_W'(2 ** CORDIC_FRAC_W);
    localparam logic signed [ANGLE_W-1:0] ANGLE_NEG_LIMIT = ANGLE_W'(-(2 ** CORDIC_FRAC_W));

    // round(atan(2^-i) * 2^(FRAC_W+GUARD)), i = 0..FRAC_W-1
    localparam logic [ATAN_W-1:0] ATAN_TABLE [CORDIC_FRAC_W] = '{
        ATAN_W'(1647099), ATAN_W'(972340), ATAN_W'(513757), ATAN_W'(260791),
        ATAN_W'(130902),  ATAN_W'(65515),  ATAN_W'(32765),  ATAN_W'(16384),
        ATAN_W'(8192),    ATAN_W'(4096),   ATAN_W'(2048),   ATAN_W'(1024),
        ATAN_W'(512),     ATAN_W'(256),    ATAN_W'(128),    ATAN_W'(64),
        ATAN_W'(32),      ATAN_W'(16),     ATAN_W'(8)
    };

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        DONE
    } cordic_state_e;

endpackage

// File: rtl/cordic_cos_fixed_if.sv
// Angle-in / cosine-out handshake bundle for cordic_cos_fixed.
interface cordic_cos_fixed_if #(
    parameter int unsigned FRAC_W = cordic_pkg::CORDIC_FRAC_W
);
    logic              valid_i;
    logic              ready_o;
    logic [FRAC_W+1:0] angle_i;
    logic              valid_o;
    logic              ready_i;
    logic              sign_o;
    logic              integer_o;
    logic [FRAC_W-1:0] fractional_o;

    modport slave (
        input  valid_i, angle_i, ready_i,
        output ready_o, valid_o, sign_o, integer_o, fractional_o
    );

    modport master (
        output valid_i, angle_i, ready_i,
        input  ready_o, valid_o, sign_o, integer_o, fractional_o
    );
endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational micro-rotation index to atan(2^-i) lookup.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int unsigned IDX_W = 5
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [ATAN_W-1:0] atan_c
);

    always_comb begin
        atan_c = '0;
        if (32'(idx) < CORDIC_FRAC_W) begin
            atan_c = ATAN_TABLE[idx];
        end
    end

endmodule

// File: rtl/cordic_cos_fixed.sv
// Iterative rotation-mode CORDIC producing cos(angle) as sign / integer bit / fraction.
module cordic_cos_fixed
    import cordic_pkg::*;
#(
    parameter int unsigned FRAC_W = CORDIC_FRAC_W,
    parameter int unsigned ITER   = 16,
    parameter int unsigned GUARD  = CORDIC_GUARD
) (
    input logic               clk,
    input logic               rst_n,
    cordic_cos_fixed_if.slave bus
);

    localparam int unsigned W     = FRAC_W + GUARD + 3;
    localparam int unsigned ANG_W = FRAC_W + 2;
    localparam int unsigned OUT_W = FRAC_W + 3;
    localparam int unsigned CNT_W = $clog2(FRAC_W);

    cordic_state_e            state;
    logic signed [W-1:0]      x, y, z;
    logic [CNT_W-1:0]         count;
    logic                     ready_q, valid_q, sign_q, int_q;
    logic [FRAC_W-1:0]        frac_q;

    logic [ATAN_W-1:0]        atan_c;
    logic signed [W-1:0]      atan_w_c;
    logic                     d_c;
    logic signed [W-1:0]      x_nxt, y_nxt, z_nxt;
    logic signed [OUT_W-1:0]  x_trunc_c;
    logic [OUT_W-1:0]         mag_c;
    logic                     sat_c;
    logic signed [ANG_W-1:0]  ang_c, ang_clamped_c;

    cordic_atan_rom #(.IDX_W(CNT_W)) u_atan_rom (
        .idx    (count),
        .atan_c (atan_c)
    );

    // Input angle limited to [-1, +1] rad where the rotation sequence converges.
    always_comb begin
        ang_c         = bus.angle_i;
        ang_clamped_c = ang_c;
        if (ang_c > ANG_W'(ANGLE_POS_LIMIT)) begin
            ang_clamped_c = ANG_W'(ANGLE_POS_LIMIT);
        end else if (ang_c < ANG_W'(ANGLE_NEG_LIMIT)) begin
            ang_clamped_c = ANG_W'(ANGLE_NEG_LIMIT);
        end
    end

    // One micro-rotation plus formatting of the rotated x for the final step.
    always_comb begin
        d_c      = ~z[W-1];
        atan_w_c = W'(atan_c);
        x_nxt    = x;
        y_nxt    = y;
        z_nxt    = z;
        if (d_c) begin
            x_nxt = x - (y >>> count);
            y_nxt = y + (x >>> count);
            z_nxt = z - atan_w_c;
        end else begin
            x_nxt = x + (y >>> count);
            y_nxt = y - (x >>> count);
            z_nxt = z + atan_w_c;
        end
        x_trunc_c = x_nxt[W-1:GUARD];
        mag_c     = x_trunc_c[OUT_W-1] ? OUT_W'(-x_trunc_c) : OUT_W'(x_trunc_c);
        sat_c     = |mag_c[OUT_W-1:FRAC_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            sign_q  <= 1'b0;
            int_q   <= 1'b0;
            frac_q  <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            count   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.valid_i && ready_q) begin
                        x       <= W'(K_SCALED) <<< GUARD;
                        y       <= '0;
                        z       <= W'(ang_clamped_c) <<< GUARD;
                        count   <= '0;
                        ready_q <= 1'b0;
                        state   <= ROTATE;
                    end
                end
                ROTATE: begin
                    x     <= x_nxt;
                    y     <= y_nxt;
                    z     <= z_nxt;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(ITER - 1)) begin
                        valid_q <= 1'b1;
                        sign_q  <= x_trunc_c[OUT_W-1];
                        int_q   <= sat_c;
                        frac_q  <= sat_c ? '0 : mag_c[FRAC_W-1:0];
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready_o      = ready_q;
    assign bus.valid_o      = valid_q;
    assign bus.sign_o       = sign_q;
    assign bus.integer_o    = int_q;
    assign bus.fractional_o = frac_q;

endmodule

// File: tb/tb_cordic_cos_fixed.sv
// Directed bench for cordic_cos_fixed: latency, handshake, clamping, backpressure and reset.
module tb_cordic_cos_fixed;

    localparam int unsigned FRAC_W = 19;
    localparam int unsigned ITER   = 16;
    localparam int          TOL    = 8;
    localparam int          ONE    = 524288;
    localparam int          COS_1  = 283274;
    localparam int          COS_05 = 460106;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    cordic_cos_fixed_if #(.FRAC_W(FRAC_W)) bus ();

    cordic_cos_fixed #(.FRAC_W(FRAC_W), .ITER(ITER), .GUARD(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Result magnitude integer*2^19 + fraction compared to an expected value with tolerance.
    task automatic chk_near(input string tag, input int exp);
        logic [31:0] obs;
        int          diff;
        obs  = 32'({bus.integer_o, bus.fractional_o});
        diff = int'(obs) - exp;
        n_cmp++;
        assert (!$isunknown(obs) && diff <= TOL && diff >= -TOL) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, TOL);
        end
    endtask

    // Accept one angle, check busy/latency every cycle, end sampled in DONE.
    task automatic run_op(input logic [20:0] angle, input int exp, input string tag);
        bus.angle_i = angle;
        bus.valid_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        chk($sformatf("%s_rdy_t0", tag), 32'(bus.ready_o), 32'd0);
        for (int k = 1; k < int'(ITER); k++) begin
            tick();
            chk($sformatf("%s_rdy_t%0d", tag, k), 32'(bus.ready_o), 32'd0);
            chk($sformatf("%s_vld_t%0d", tag, k), 32'(bus.valid_o), 32'd0);
        end
        tick();
        chk($sformatf("%s_vld_done", tag), 32'(bus.valid_o), 32'd1);
        chk($sformatf("%s_rdy_done", tag), 32'(bus.ready_o), 32'd0);
        chk($sformatf("%s_sign", tag), 32'(bus.sign_o), 32'd0);
        chk_near($sformatf("%s_val", tag), exp);
    endtask

    task automatic chk_idle(input string tag);
        chk($sformatf("%s_rdy", tag), 32'(bus.ready_o), 32'd1);
        chk($sformatf("%s_vld", tag), 32'(bus.valid_o), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.valid_i = 1'b0;
        bus.angle_i = '0;
        bus.ready_i = 1'b1;
        tick();
        tick();
        chk_idle("reset");
        chk("reset_sign", 32'(bus.sign_o), 32'd0);
        chk("reset_int", 32'(bus.integer_o), 32'd0);
        chk("reset_frac", 32'(bus.fractional_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // cos(0) lands within a few LSB of 1.0, either just below or saturated.
        run_op(21'h000000, ONE, "cos_0");
        tick();
        chk_idle("cos_0_release");

        run_op(21'h080000, COS_1, "cos_p1");
        tick();
        chk_idle("cos_p1_release");

        run_op(21'h180000, COS_1, "cos_m1");
        tick();
        chk_idle("cos_m1_release");

        run_op(21'h1C0000, COS_05, "cos_m05");
        tick();
        chk_idle("cos_m05_release");

        run_op(21'h0C0000, COS_1, "clamp_p15");
        tick();
        chk_idle("clamp_p15_release");

        run_op(21'h140000, COS_1, "clamp_m15");
        tick();
        chk_idle("clamp_m15_release");

        // Backpressure: result held, stray valid_i pulses ignored.
        bus.ready_i = 1'b0;
        run_op(21'h1C0000, COS_05, "bp");
        for (int k = 0; k < 10; k++) begin
            bus.angle_i = 21'h000000;
            bus.valid_i = (k % 3 == 0);
            tick();
            chk($sformatf("bp_vld_%0d", k), 32'(bus.valid_o), 32'd1);
            chk($sformatf("bp_rdy_%0d", k), 32'(bus.ready_o), 32'd0);
            chk($sformatf("bp_sign_%0d", k), 32'(bus.sign_o), 32'd0);
            chk_near($sformatf("bp_val_%0d", k), COS_05);
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        tick();
        chk_idle("bp_release");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_idle($sformatf("bp_no_queue_%0d", k));
        end

        // Reset while rotation index 7 is pending discards the operation.
        bus.angle_i = 21'h080000;
        bus.valid_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
        end
        chk("midrst_busy", 32'(bus.ready_o), 32'd0);
        rst_n = 1'b0;
        tick();
        chk_idle("midrst");
        chk("midrst_sign", 32'(bus.sign_o), 32'd0);
        chk("midrst_int", 32'(bus.integer_o), 32'd0);
        chk("midrst_frac", 32'(bus.fractional_o), 32'd0);
        rst_n = 1'b1;
        tick();
        chk_idle("midrst_released");
        run_op(21'h080000, COS_1, "post_rst");
        tick();
        chk_idle("post_rst_release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
